cla_sweep_checker: RTL
======================

# cla_sweep_checker

Self-checking stimulus/response engine for the 4-bit carry lookahead adder. It drives the adder's A and B operand inputs through a full operand sweep and waits a programmable settle time per vector. It then samples the adder's S output, checks it against the modulo-2^WIDTH sum, and reports an error count, the first failing vector and a pass/done status. It sits next to the adder as its consumer: it generates the operands and checks the sum the adder returns.

## Interface
- WIDTH, 4, operand/sum width in bits
- SWEEP_MAX, 7, highest value each operand takes (0..SWEEP_MAX, must be < 2^WIDTH)
- SETTLE_CYC, 2, cycles each vector is held before the sum is sampled (>= 1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a sweep; sampled in IDLE or DONE only
- a_out  out  WIDTH  operand A to adder
- b_out  out  WIDTH  operand B to adder
- sum_in  in  WIDTH  adder sum S
- busy  out  1  sweep in progress
- done  out  1  sweep finished, held until next start
- pass  out  1  done and err_count == 0
- err_count  out  8  mismatch count, saturating at 255
- first_err_a / first_err_b / first_err_sum  out  WIDTH each  operands and observed sum of first mismatch; valid only when err_count != 0

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1:
  - a_out=0, b_out=0, settle counter=0, err_count=0.
  - first_err_* = 0, done=0.
  - Next state: SETTLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter == SETTLE_CYC-1, go to CHECK.
- CHECK, single cycle:
  - Expected sum = (a_out + b_out) truncated to WIDTH; carry-out is ignored.
  - If sum_in != expected, err_count increments (saturating).
  - If this is the first mismatch, capture a_out, b_out and sum_in into first_err_*.
- CHECK, advance to the next vector:
  - If b_out < SWEEP_MAX: b_out+1.
  - Else if a_out < SWEEP_MAX: a_out+1, b_out=0.
  - Else go to DONE (operands hold their last values).
  - Otherwise return to SETTLE with counter=0.
- Vector order is A-major, B-minor: (0,0),(0,1)…(0,SWEEP_MAX),(1,0)…(SWEEP_MAX,SWEEP_MAX).
- busy=1 in SETTLE and CHECK; start is ignored while busy.
- DONE: done=1 and pass=(err_count==0). The state holds until start.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE.
- Reset asserted mid-sweep aborts immediately: all outputs go to 0 and no partial result is retained.
- The vector changes on the CHECK-exit edge. sum_in is sampled on the CHECK edge, SETTLE_CYC cycles after the operands change.
- Each vector takes SETTLE_CYC+1 cycles.
- A full sweep takes (SWEEP_MAX+1)^2 × (SETTLE_CYC+1) cycles from the edge sampling start to the edge setting done. Defaults: 64 × 3 = 192.
- busy rises on the edge after start and falls on the same edge that done rises.
- Simultaneous start and DONE: restart takes priority; done clears on that edge.

## Structure
- Shared package cla_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the ERR_W=8 constant;
  - the saturating-increment function.
- One sub-module, cla_vec_gen: the nested A/B sweep counter. It has inputs clear and step, and outputs a, b and last.
- Top-level: FSM, settle counter, comparator, error capture.

## Test plan
- Ideal adder model, defaults, start pulse:
  - done=1 exactly 192 cycles later, pass=1, err_count=0.
  - busy high for those 192 cycles.
- Adder with sum bit 0 stuck at 0:
  - err_count=32 (every odd sum), pass=0.
  - first_err_a=0, first_err_b=1, first_err_sum=0.
- Adder output inverted (~(A+B)): err_count=64; first_err = (0,0,15).
- start pulsed at cycle 40 of a sweep: ignored; done still at cycle 192 and counts unchanged.
- rst_n low at cycle 50 mid-sweep:
  - all outputs 0 asynchronously, state IDLE.
  - A new start then completes in 192 cycles with pass=1.
- WIDTH=4, SWEEP_MAX=15, SETTLE_CYC=1, ideal adder:
  - vector (15,1) expects 0 (wrap-around) with no error.
  - done after 512 cycles, pass=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the carry-lookahead adder sweep checker.
package cla_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int unsigned ERR_W = 8;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cla_vec_gen.sv
// Nested A/B operand counter: B is the fast digit, A the slow one, both 0..SWEEP_MAX.
module cla_vec_gen #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SWEEP_MAX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(SWEEP_MAX);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clear) begin
            a_d = '0;
            b_d = '0;
        end else if (step) begin
            if (b_q < MAXV) begin
                b_d = b_q + 1'b1;
            end else if (a_q < MAXV) begin
                a_d = a_q + 1'b1;
                b_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a    = a_q;
    assign b    = b_q;
    assign last = (a_q == MAXV) && (b_q == MAXV);

endmodule

// File: rtl/cla_sweep_checker.sv
// Drives a full A/B operand sweep into the adder and checks each returned sum
// against the modulo-2^WIDTH reference, recording error count and first failure.
module cla_sweep_checker
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned SWEEP_MAX  = 7,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_sum
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d, fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             vec_clear, vec_step, vec_last;
    logic [WIDTH-1:0] vec_a, vec_b, exp_sum;

    cla_vec_gen #(
        .WIDTH     (WIDTH),
        .SWEEP_MAX (SWEEP_MAX)
    ) u_vec_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (vec_clear),
        .step  (vec_step),
        .a     (vec_a),
        .b     (vec_b),
        .last  (vec_last)
    );

    // Carry-out is dropped by the WIDTH-bit result.
    assign exp_sum = vec_a + vec_b;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        fs_d      = fs_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        vec_clear = 1'b0;
        vec_step  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    cnt_d     = '0;
                    err_d     = '0;
                    fa_d      = '0;
                    fb_d      = '0;
                    fs_d      = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    vec_clear = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (sum_in != exp_sum) begin
                    err_d = sat_inc(err_q);
                    if (err_q == '0) begin
                        fa_d = vec_a;
                        fb_d = vec_b;
                        fs_d = sum_in;
                    end
                end
                // pass uses the post-update count so a failing last vector is seen.
                if (vec_last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_step = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            fs_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign a_out         = vec_a;
    assign b_out         = vec_b;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_a   = fa_q;
    assign first_err_b   = fb_q;
    assign first_err_sum = fs_q;

endmodule
